buzzer_axil_slave: RTL and testbench

AXI4-Lite slave register file and square-wave tone generator for the BUZZER IP. It answers transactions from the processor-side AXI4-Lite master (PS or verification master VIP). It holds four 32-bit read/write registers and drives a single buzzer pin from them.

---
 rtl/buzzer_axil_slave_if.sv | 39 +++
 rtl/buzzer_axil_slave.sv | 160 ++++++++++++++++
 tb/tb_buzzer_axil_slave.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_axil_slave_if.sv
// rtl/buzzer_axil_slave_if.sv - AXI4-Lite bus bundle between the processor-side master and the buzzer slave
interface buzzer_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/buzzer_axil_slave.sv
// rtl/buzzer_axil_slave.sv - AXI4-Lite register file (CTRL/HALF_PERIOD/DURATION/SCRATCH) driving a square-wave buzzer
// Optional one-shot tone length when BUZZER_DURATION_EN is defined.
module buzzer_axil_slave (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  buzzer_axil_slave_if.slave   s_axi,
  output logic                 buzzer_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_e;

  logic [31:0] regs_q [4];
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        restart_q;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;

  logic        wr_hs, rd_hs, restart_d;
  logic [1:0]  wsel, rsel;
  logic        tone_en, hp_hit;
  logic        unused_axi;

  assign wsel  = s_axi.S_AXI_AWADDR[3:2];
  assign rsel  = s_axi.S_AXI_ARADDR[3:2];
  // Ready is combinational so a held-BREADY master gets one write every two cycles.
  assign wr_hs = ARESETN && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q;
  assign rd_hs = ARESETN && s_axi.S_AXI_ARVALID && !rvalid_q;

  assign s_axi.S_AXI_AWREADY = wr_hs;
  assign s_axi.S_AXI_WREADY  = wr_hs;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = rd_hs;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign unused_axi = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (wr_hs) begin
      for (int b = 0; b < 4; b++)
        if (s_axi.S_AXI_WSTRB[b]) regs_q[wsel][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (wr_hs)                            bvalid_q <= 1'b1;
      else if (s_axi.S_AXI_BREADY)          bvalid_q <= 1'b0;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= regs_q[rsel];
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Restart is applied one cycle after the write so the FSM sees the new register values.
  assign restart_d = wr_hs && (wsel == 2'd0 || wsel == 2'd1) && (|s_axi.S_AXI_WSTRB);
  assign tone_en   = regs_q[0][0] && (regs_q[1] != 32'd0);
  assign hp_hit    = (cnt_q == regs_q[1] - 32'd1);

`ifdef BUZZER_DURATION_EN
  logic [31:0] periods_q, periods_d, periods_inc;
  logic        done_q, done_d;
  assign periods_inc = (periods_q == '1) ? periods_q : periods_q + 32'd1;
  assign done        = done_q;
`else
  assign done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
`ifdef BUZZER_DURATION_EN
    periods_d = periods_q;
    done_d    = 1'b0;
`endif
    if (restart_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      armed_d = 1'b1;
`ifdef BUZZER_DURATION_EN
      periods_d = '0;
`endif
    end else if (!tone_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (armed_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end
        ST_HIGH: if (hp_hit) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        ST_LOW: if (hp_hit) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
`ifdef BUZZER_DURATION_EN
          periods_d = periods_inc;
          if (regs_q[2] != 32'd0 && periods_inc >= regs_q[2]) begin
            state_d = ST_IDLE;
            armed_d = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      restart_q <= 1'b0;
`ifdef BUZZER_DURATION_EN
      periods_q <= '0;
      done_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      restart_q <= restart_d;
`ifdef BUZZER_DURATION_EN
      periods_q <= periods_d;
      done_q    <= done_d;
`endif
    end
  end

  assign buzzer_out = (state_q == ST_HIGH);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_buzzer_axil_slave.sv
// tb/tb_buzzer_axil_slave.sv - directed and randomized bench for buzzer_axil_slave against a register/tone model
module tb_buzzer_axil_slave;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic buzzer_out, busy, done;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] model [4];

`ifdef BUZZER_DURATION_EN
  localparam bit DUR_EN = 1'b1;
`else
  localparam bit DUR_EN = 1'b0;
`endif

  buzzer_axil_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  buzzer_axil_slave dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .s_axi      (bus),
    .buzzer_out (buzzer_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_awready"}, bus.S_AXI_AWREADY, 1'b0);
    check1({tag, "_wready"},  bus.S_AXI_WREADY,  1'b0);
    check1({tag, "_bvalid"},  bus.S_AXI_BVALID,  1'b0);
    check1({tag, "_arready"}, bus.S_AXI_ARREADY, 1'b0);
    check1({tag, "_rvalid"},  bus.S_AXI_RVALID,  1'b0);
    check32({tag, "_rdata"},  bus.S_AXI_RDATA,   32'h0);
    check1({tag, "_buzzer"},  buzzer_out,        1'b0);
    check1({tag, "_busy"},    busy,              1'b0);
    check1({tag, "_done"},    done,              1'b0);
  endtask

  task automatic model_write(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_AWREADY) break;
    end
    check1("aw_accept", bus.S_AXI_AWREADY, 1'b1);
    check1("w_accept",  bus.S_AXI_WREADY,  1'b1);
    @(posedge ACLK);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    model_write(addr[3:2], data, strb);
    check1("bvalid", bus.S_AXI_BVALID, 1'b1);
    check32("bresp", {30'd0, bus.S_AXI_BRESP}, 32'h0);
  endtask

  task automatic axi_read(input logic [3:0] addr);
    logic [31:0] exp;
    exp = model[addr[3:2]];
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_ARREADY) break;
    end
    check1("ar_accept", bus.S_AXI_ARREADY, 1'b1);
    @(posedge ACLK);
    #1;
    bus.S_AXI_ARVALID = 1'b0;
    check1("rvalid", bus.S_AXI_RVALID, 1'b1);
    check32("rdata", bus.S_AXI_RDATA, exp);
    check32("rresp", {30'd0, bus.S_AXI_RRESP}, 32'h0);
  endtask

  // Expected waveform from the write edge: idle for 2 edges, then HIGH hp / LOW hp, optionally for dur periods.
  task automatic check_tone(input int hp, input int dur, input int ncyc, input int c0);
    int k, t;
    logic active, exp_buz, exp_done;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge ACLK);
      #1;
      k = cyc - c0;
      t = k - 2;
      active   = (k >= 2) && ((dur == 0) || (t < 2 * hp * dur));
      exp_buz  = active && ((t % (2 * hp)) < hp);
      exp_done = (dur != 0) && (k >= 2) && (t == 2 * hp * dur);
      check1("tone_buzzer", buzzer_out, exp_buz);
      check1("tone_busy",   busy,       active);
      check1("tone_done",   done,       exp_done);
    end
  endtask

  task automatic check_stop();
    @(posedge ACLK);
    #1;
    check1("stop_buzzer", buzzer_out, 1'b0);
    check1("stop_busy",   busy,       1'b0);
  endtask

  initial begin
    int c0, hp, dur_eff;
    logic [1:0] idx;
    logic [31:0] data;
    logic [3:0] strb;

    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    // Valids held high during reset: readies must still stay low.
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check_all_zero("reset");
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;

    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'hC, 32'd4, 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

    for (int i = 0; i < 24; i++) begin
      idx  = 2'($urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      axi_write({idx, 2'($urandom_range(0, 3))}, data, strb);
      axi_read({2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
    end

    axi_write(4'hC, 32'h0, 4'hF);
    axi_write(4'hC, 32'hAABBCCDD, 4'b0101);
    axi_read(4'hC);
    check32("strobe_model", model[3], 32'h00BB00DD);

    axi_write(4'h0, 32'd0, 4'hF);
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'h4, 32'd5, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    c0 = cyc;
    check_tone(5, 0, 42, c0);
    axi_write(4'h0, 32'd0, 4'hF);
    check_stop();

    hp = $urandom_range(1, 6);
    axi_write(4'h4, 32'(hp), 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    c0 = cyc;
    check_tone(hp, 0, 4 * hp + 6, c0);
    axi_write(4'h0, 32'd0, 4'hF);
    check_stop();

    dur_eff = DUR_EN ? 3 : 0;
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    for (int rep = 0; rep < 2; rep++) begin
      axi_write(4'h0, 32'd1, 4'hF);
      c0 = cyc;
      check_tone(2, dur_eff, 20, c0);
    end
    axi_read(4'h0);
    axi_write(4'h0, 32'd0, 4'hF);
    check_stop();

    bus.S_AXI_BREADY = 1'b0;
    axi_write(4'hC, 32'h11, 4'hF);
    bus.S_AXI_AWADDR  = 4'hC;
    bus.S_AXI_WDATA   = 32'h22;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check1("hold_awready", bus.S_AXI_AWREADY, 1'b0);
      check1("hold_wready",  bus.S_AXI_WREADY,  1'b0);
      check1("hold_bvalid",  bus.S_AXI_BVALID,  1'b1);
    end
    bus.S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_AWREADY) break;
    end
    check1("second_aw_accept", bus.S_AXI_AWREADY, 1'b1);
    @(posedge ACLK);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    model_write(2'd3, 32'h22, 4'hF);
    check1("second_bvalid", bus.S_AXI_BVALID, 1'b1);
    axi_read(4'hC);

    axi_write(4'h4, 32'd3, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    bus.S_AXI_RREADY = 1'b0;
    axi_read(4'hC);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (buzzer_out) break;
    end
    check1("high_phase", buzzer_out, 1'b1);
    check1("rvalid_pending", bus.S_AXI_RVALID, 1'b1);
    ARESETN = 1'b0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge ACLK);
    #1;
    check_all_zero("held_reset");
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    ARESETN = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
    check1("post_reset_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
